// File: rtl/std_countdown_timer_if.sv
// Handshake bundle for the countdown timer.
// master drives control, slave returns status.
interface std_countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_stop;
  logic [WIDTH-1:0] i_load_value;
  logic             i_tick_en;
  logic             o_busy;
  logic [WIDTH-1:0] o_count;
  logic             o_expire;

  modport master (
    output i_start,
    output i_stop,
    output i_load_value,
    output i_tick_en,
    input  o_busy,
    input  o_count,
    input  o_expire
  );

  modport slave (
    input  i_start,
    input  i_stop,
    input  i_load_value,
    input  i_tick_en,
    output o_busy,
    output o_count,
    output o_expire
  );
endinterface

// File: rtl/std_countdown_timer.sv
// Loadable down-counting timer with prescaler.
// Emits a registered one-cycle expire pulse at zero.
module std_countdown_timer #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE_MAX = 0,
  parameter bit AUTO_RELOAD  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  std_countdown_timer_if.slave bus
);
  localparam int PW =
    (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE_MAX);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             expire_q, expire_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    expire_d = 1'b0;
    if (bus.i_stop) begin
      state_d = S_IDLE;
      count_d = '0;
      pre_d   = '0;
    end else if (bus.i_start) begin
      reload_d = bus.i_load_value;
      count_d  = bus.i_load_value;
      pre_d    = '0;
      if (bus.i_load_value != '0) begin
        state_d = S_RUN;
      end else begin
        state_d  = S_IDLE;
        expire_d = 1'b1;
      end
    end else if (state_q == S_RUN && bus.i_tick_en) begin
      if (pre_q != PMAX) begin
        pre_d = pre_q + PW'(1);
      end else begin
        pre_d = '0;
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // count is 1 here: RUN never holds a zero count
          expire_d = 1'b1;
          if (AUTO_RELOAD) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = S_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      expire_q <= expire_d;
    end
  end

  assign bus.o_busy   = (state_q == S_RUN);
  assign bus.o_count  = count_q;
  assign bus.o_expire = expire_q;
endmodule
